// File: rtl/config_pkg.sv
// Shared configuration constants and types for the oscillator pipeline.
package CONFIG;

  localparam int LONG_PERCENT_WIDTH = 8;

  typedef logic [LONG_PERCENT_WIDTH-1:0] long_percent_t;

endpackage : CONFIG

// File: rtl/oscillator_pkg.sv
// Oscillator types: quarter-wave lookup state and the quadrant decode helper.
package OSCILLATOR;

  typedef enum logic {
    FRONT = 1'b0,
    BACK  = 1'b1
  } oscillator_state_t;

  // Encoding matches the top two accumulator bits: bit 1 is the sign, bit 0 the half.
  typedef enum logic [1:0] {
    Q_FRONT_POS = 2'd0,
    Q_BACK_POS  = 2'd1,
    Q_FRONT_NEG = 2'd2,
    Q_BACK_NEG  = 2'd3
  } quadrant_t;

  function automatic oscillator_state_t quadrant_to_state(input quadrant_t q);
    return (q == Q_BACK_POS || q == Q_BACK_NEG) ? BACK : FRONT;
  endfunction

endpackage : OSCILLATOR

// File: rtl/sine_phase_driver.sv
// Phase accumulator driving the quarter-wave sine lookup, with quadrant/sign decode
// and a one-cycle delayed sign aligned with the lookup's registered output.
module sine_phase_driver
  import CONFIG::*;
  import OSCILLATOR::*;
#(
  parameter  int FRAC_WIDTH = 8,
  localparam int ACC_WIDTH  = LONG_PERCENT_WIDTH + 2 + FRAC_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_l,
  input  logic                 tick,
  input  logic [ACC_WIDTH-1:0] step,
  input  logic                 step_load,
  input  logic                 retrigger,
  output oscillator_state_t    state,
  output long_percent_t        phase,
  output logic                 negate,
  output logic                 negate_aligned,
  output logic                 wrap
);

  logic [ACC_WIDTH-1:0] acc_reg;
  logic [ACC_WIDTH-1:0] step_reg;
  logic [ACC_WIDTH:0]   sum;
  quadrant_t            quadrant;

  // One extra bit on the adder so the carry-out becomes the wrap pulse.
  assign sum = {1'b0, acc_reg} + {1'b0, step_reg};

  // Outputs decode straight from the register, so they change only at clock edges.
  assign quadrant = quadrant_t'(acc_reg[ACC_WIDTH-1 -: 2]);
  assign phase    = acc_reg[ACC_WIDTH-3 -: LONG_PERCENT_WIDTH];
  assign state    = quadrant_to_state(quadrant);
  assign negate   = (quadrant == Q_FRONT_NEG) || (quadrant == Q_BACK_NEG);

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      acc_reg        <= '0;
      step_reg       <= '0;
      negate_aligned <= 1'b0;
      wrap           <= 1'b0;
    end else begin
      if (retrigger) begin
        acc_reg <= '0;
        wrap    <= 1'b0;
      end else if (tick) begin
        acc_reg <= sum[ACC_WIDTH-1:0];
        wrap    <= sum[ACC_WIDTH];
      end else begin
        wrap    <= 1'b0;
      end
      // A load colliding with a tick lands after the add, which used the old step.
      if (step_load) begin
        step_reg <= step;
      end
      negate_aligned <= negate;
    end
  end

endmodule : sine_phase_driver

// File: tb/tb_sine_phase_driver.sv
// Directed bench for sine_phase_driver: one integer-phase instance and one fractional instance.
module tb_sine_phase_driver;
  import OSCILLATOR::*;

  logic clock   = 1'b0;
  logic reset_l = 1'b1;

  // FRAC_WIDTH = 0 instance: accumulator is 10 bits
  logic              tick0 = 1'b0, load0 = 1'b0, retrig0 = 1'b0;
  logic [9:0]        step0 = '0;
  oscillator_state_t state0;
  logic [7:0]        phase0;
  logic              negate0, nal0, wrap0;
  logic [9:0]        acc0_obs;

  // FRAC_WIDTH = 8 instance: accumulator is 18 bits
  logic              tick8 = 1'b0, load8 = 1'b0, retrig8 = 1'b0;
  logic [17:0]       step8 = '0;
  oscillator_state_t state8;
  logic [7:0]        phase8;
  logic              negate8, nal8, wrap8;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sine_phase_driver #(.FRAC_WIDTH(0)) dut0 (
    .clock(clock), .reset_l(reset_l), .tick(tick0), .step(step0),
    .step_load(load0), .retrigger(retrig0), .state(state0), .phase(phase0),
    .negate(negate0), .negate_aligned(nal0), .wrap(wrap0)
  );

  sine_phase_driver #(.FRAC_WIDTH(8)) dut8 (
    .clock(clock), .reset_l(reset_l), .tick(tick8), .step(step8),
    .step_load(load8), .retrigger(retrig8), .state(state8), .phase(phase8),
    .negate(negate8), .negate_aligned(nal8), .wrap(wrap8)
  );

  // With no fractional bits the accumulator is fully visible as {sign, half, phase}.
  assign acc0_obs = {negate0, (state0 == BACK), phase0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int m, prev_neg, wraps, e;

    // reset state, asserted before any clock edge
    #1 reset_l = 1'b0;
    #2;
    check("rst_state",  32'(state0), 32'(FRONT));
    check("rst_phase",  32'(phase0), 0);
    check("rst_negate", 32'(negate0), 0);
    check("rst_nal",    32'(nal0), 0);
    check("rst_wrap",   32'(wrap0), 0);
    check("rst_phase8", 32'(phase8), 0);
    repeat (2) @(negedge clock);
    reset_l = 1'b1;
    cyc();
    check("idle_acc", 32'(acc0_obs), 0);
    $display("reset: initial state checked");

    // quadrant walk, step 1, tick every cycle
    load0 = 1'b1; step0 = 10'd1;
    cyc();
    load0 = 1'b0; tick0 = 1'b1;
    prev_neg = 0; wraps = 0;
    for (int n = 1; n <= 1024; n++) begin
      cyc();
      m = n % 1024;
      check("walk_acc",  32'(acc0_obs), 32'(m));
      check("walk_nal",  32'(nal0), 32'(prev_neg));
      check("walk_wrap", 32'(wrap0), 32'(n == 1024));
      if (wrap0) wraps++;
      prev_neg = (m >> 9) & 1;
      if (n == 256) begin
        check("q1_state", 32'(state0), 32'(BACK));
        check("q1_phase", 32'(phase0), 0);
      end
      if (n == 512) begin
        check("q2_state",  32'(state0), 32'(FRONT));
        check("q2_negate", 32'(negate0), 1);
        check("q2_nal_lag", 32'(nal0), 0);
      end
      if (n == 513) check("q2_nal_rise", 32'(nal0), 1);
    end
    tick0 = 1'b0;
    cyc();
    check("walk_wrap_once", 32'(wraps), 1);
    check("walk_wrap_drop", 32'(wrap0), 0);
    $display("walk: 1024 ticks through four quadrants");

    // step load collision
    load0 = 1'b1; step0 = 10'd3;
    cyc();
    check("ld3_no_tick", 32'(acc0_obs), 0);
    step0 = 10'd5; tick0 = 1'b1;
    cyc();
    check("coll_old_step", 32'(acc0_obs), 3);
    load0 = 1'b0;
    cyc();
    check("coll_new_step", 32'(acc0_obs), 8);
    tick0 = 1'b0; load0 = 1'b1; step0 = 10'd780;
    cyc();
    check("hold_no_tick", 32'(acc0_obs), 8);
    load0 = 1'b0; tick0 = 1'b1;
    cyc();
    check("to_q3_acc",  32'(acc0_obs), 788);
    check("to_q3_wrap", 32'(wrap0), 0);
    $display("collision: +3 then +5");

    // retrigger beats tick, in quadrant 3
    tick0 = 1'b0;
    cyc();
    check("q3_state",  32'(state0), 32'(BACK));
    check("q3_phase",  32'(phase0), 20);
    check("q3_negate", 32'(negate0), 1);
    check("q3_nal",    32'(nal0), 1);
    retrig0 = 1'b1; tick0 = 1'b1;
    cyc();
    check("rt_acc",    32'(acc0_obs), 0);
    check("rt_wrap",   32'(wrap0), 0);
    check("rt_negate", 32'(negate0), 0);
    check("rt_nal",    32'(nal0), 1);
    retrig0 = 1'b0; tick0 = 1'b0;
    cyc();
    check("rt_nal_fall", 32'(nal0), 0);
    $display("retrigger: priority over tick");

    // zero step holds
    load0 = 1'b1; step0 = 10'd0;
    cyc();
    load0 = 1'b0; tick0 = 1'b1;
    repeat (3) begin
      cyc();
      check("zstep_acc",  32'(acc0_obs), 0);
      check("zstep_wrap", 32'(wrap0), 0);
    end
    tick0 = 1'b0;
    $display("zero step: accumulator holds");

    // fractional stepping, step 0x80
    load8 = 1'b1; step8 = 18'h80;
    cyc();
    load8 = 1'b0; tick8 = 1'b1;
    for (int n = 1; n <= 3148; n++) begin
      cyc();
      e = (n * 128) % 262144;
      check("frac_phase",  32'(phase8), 32'((n / 2) % 256));
      check("frac_state",  32'(state8), 32'((e >> 16) & 1));
      check("frac_negate", 32'(negate8), 32'(e >> 17));
      check("frac_wrap",   32'(wrap8), 32'(n == 2048));
    end
    tick8 = 1'b0;
    cyc();
    check("frac_hold_phase", 32'(phase8), 38);
    check("frac_hold_neg",   32'(negate8), 1);
    check("frac_hold_nal",   32'(nal8), 1);
    $display("fractional: 3148 ticks at half-index rate");

    // asynchronous reset mid-cycle
    #2 reset_l = 1'b0;
    #1;
    check("arst_state",  32'(state8), 32'(FRONT));
    check("arst_phase",  32'(phase8), 0);
    check("arst_negate", 32'(negate8), 0);
    check("arst_nal",    32'(nal8), 0);
    check("arst_wrap",   32'(wrap8), 0);
    @(negedge clock);
    reset_l = 1'b1;
    cyc();
    check("post_rst_hold", 32'(phase8), 0);
    tick8 = 1'b1;
    repeat (3) begin
      cyc();
      check("post_rst_step0", 32'(phase8), 0);
      check("post_rst_wrap",  32'(wrap8), 0);
    end
    tick8 = 1'b0;
    $display("async reset: cleared without clock edge");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sine_phase_driver

// File: doc/sine_phase_driver.md
# sine_phase_driver

Numerically controlled phase generator that drives the quarter-wave sine lookup in the oscillator pipeline. It accumulates a per-sample phase step and decodes the accumulator into the lookup's `state` (FRONT/BACK) and `phase` inputs. It also supplies a half-cycle sign that downstream logic uses to negate the unsigned lookup output. The sign is delivered twice: once unregistered-aligned with `phase`, and once delayed one cycle to line up with the lookup's registered output.

## Interface
- `FRAC_WIDTH`, 8: fractional accumulator bits below the lookup index, for fine frequency resolution.
- `ACC_WIDTH`, `CONFIG::LONG_PERCENT_WIDTH + 2 + FRAC_WIDTH`: accumulator and step width (derived, not overridden).
- `clock`  in  1: system clock.
- `reset_l`  in  1: asynchronous, active-low reset.
- `tick`  in  1: one-cycle sample strobe; the accumulator advances only on `tick`.
- `step`  in  ACC_WIDTH: phase increment per tick, unsigned.
- `step_load`  in  1: captures `step` into the active step register.
- `retrigger`  in  1: restarts the cycle at phase zero (note-on).
- `state`  out  `OSCILLATOR::oscillator_state_t`: FRONT in quadrants 0 and 2, BACK in quadrants 1 and 3.
- `phase`  out  `CONFIG::long_percent_t`: lookup index.
- `negate`  out  1: high in quadrants 2 and 3, aligned with `phase`.
- `negate_aligned`  out  1: `negate` delayed one cycle, aligned with the lookup's output.
- `wrap`  out  1: one-cycle pulse when the accumulator overflows past a full cycle.

## Operation
- Registers:
  - `acc` (ACC_WIDTH)
  - `step_reg` (ACC_WIDTH)
  - `negate_aligned`
  - `wrap`
- Field decode, combinational from `acc` only, so the outputs are glitch-free register decodes:
  - `quadrant` = `acc[ACC_WIDTH-1 -: 2]`
  - `phase` = the next `LONG_PERCENT_WIDTH` bits
  - the low `FRAC_WIDTH` bits are discarded
- Quadrant map:
  - 0: FRONT, positive
  - 1: BACK, positive
  - 2: FRONT, negative
  - 3: BACK, negative
- Accumulator priority, per edge:
  1. `retrigger`: `acc <= 0`.
  2. Else `tick`: `acc <= acc + step_reg`, modulo 2^ACC_WIDTH.
  3. Else hold.
- `wrap` is the carry-out of the tick addition. It is 0 on retrigger and on non-tick cycles.
- `step_load` sets `step_reg <= step` independently of the priority above.
  - If `step_load` and `tick` occur in the same cycle, the addition uses the old `step_reg`.
  - The new step takes effect from the next tick.
- `negate_aligned <= negate` every cycle, unconditionally.
- `step_reg` = 0 is legal: the accumulator holds and `wrap` never fires.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert handled upstream) sets:
  - `acc` = 0, so `state` = FRONT, `phase` = 0, `negate` = 0
  - `step_reg` = 0
  - `negate_aligned` = 0
  - `wrap` = 0
- Latency:
  - tick at edge N: new `phase`/`state`/`negate` are visible after edge N.
  - The lookup output for that phase is valid after edge N+1, together with `negate_aligned`.
- `wrap` is high for exactly the cycle following the overflowing tick edge.
- Retrigger asserted with tick: the tick is ignored and `acc` = 0 next cycle.
- Retrigger asserted mid-cycle in quadrant 3: the sign flips to positive immediately. The `negate_aligned` transition follows one cycle later.
- Consecutive ticks on every clock are supported (tick tied high).
- Reset asserted mid-cycle clears all state within the same cycle, without waiting for a clock edge.

## Structure
- The `OSCILLATOR` package owns:
  - the existing `oscillator_state_t`
  - a new `quadrant_t` enum (`Q_FRONT_POS`, `Q_BACK_POS`, `Q_FRONT_NEG`, `Q_BACK_NEG`)
  - a `quadrant_to_state` function
- `CONFIG` owns `LONG_PERCENT_WIDTH` and the `long_percent_t` typedef. No new constants go in `CONFIG`.
- No sub-module. The quadrant decode is a package function. The lookup itself is instantiated by the parent oscillator, not inside this block.

## Test plan
- Reset:
  - Stimulus: `reset_l` = 0 mid-run with `acc` nonzero.
  - Required response: all outputs 0/FRONT without a clock edge. After release, values hold until the first tick.
- Quadrant walk, with `FRAC_WIDTH`=0:
  - Stimulus: `step`=1 loaded, tick held high.
  - Required response:
    - After 2^W ticks (W = `LONG_PERCENT_WIDTH`): `state`=BACK, `phase`=0.
    - After 2·2^W ticks: FRONT, `negate`=1.
    - After 4·2^W ticks: `wrap` pulses once, `acc`=0.
- Sign alignment:
  - Required response: `negate_aligned` equals the previous cycle's `negate` on every cycle.
  - Required response: at the quadrant 1→2 boundary, `negate` rises one cycle before `negate_aligned`.
- Step load collision, with `FRAC_WIDTH`=0:
  - Stimulus: `step_reg`=3, then `step_load` with `step`=5 on the same cycle as a tick.
  - Required response: `acc` +3 on that tick, +5 on the next tick.
- Retrigger priority:
  - Stimulus: `acc` in quadrant 3; `retrigger` and `tick` asserted together.
  - Required response: next cycle `acc`=0, `wrap`=0, `negate`=0; `negate_aligned`=1 for one more cycle, then 0.
- Fractional stepping, with `FRAC_WIDTH`=8:
  - Stimulus: `step`=0x80.
  - Required response: `phase` increments by 1 every 2 ticks; no `wrap` before 2·2^(W+2) ticks.
